// File: rtl/router_packet_tx.sv
// Bit-serial packet source for one router input port: address, gated padding, payload.
// Define TX_PARITY_EN to append an even-parity bit after the payload.
module router_packet_tx #(
    parameter int DATA_W     = 8,
    parameter int PAD_CYCLES = 4,
    parameter int IFG        = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              dest_busy,
    input  logic              tx_pause,
    output logic              din,
    output logic              valid_n,
    output logic              frame_n,
    output logic              tx_active
);

`ifdef TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CW = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_PAD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       addr_q, addr_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic             din_q, din_d;
    logic             valid_n_q, valid_n_d;
    logic             frame_n_q, frame_n_d;
    logic             ready_q, ready_d;
    logic             active_q, active_d;
    logic [NBITS-1:0] load_v;

`ifdef TX_PARITY_EN
    assign load_v = {req_data, ^req_data};
`else
    assign load_v = req_data;
`endif

    // Outputs are computed for the cycle that follows the edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        sr_d      = sr_q;
        din_d     = 1'b0;
        valid_n_d = 1'b1;
        frame_n_d = 1'b1;
        ready_d   = 1'b0;
        active_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d   = S_ADDR;
                    addr_d    = {req_addr[2:0], 1'b0};
                    sr_d      = load_v;
                    cnt_d     = '0;
                    din_d     = req_addr[3];
                    frame_n_d = 1'b0;
                    active_d  = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_ADDR: begin
                frame_n_d = 1'b0;
                active_d  = 1'b1;
                if (cnt_q == CW'(3)) begin
                    state_d = S_PAD;
                    cnt_d   = '0;
                end else begin
                    din_d  = addr_q[3];
                    addr_d = {addr_q[2:0], 1'b0};
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            S_PAD: begin
                frame_n_d = 1'b0;
                active_d  = 1'b1;
                if (!dest_busy) begin
                    if (cnt_q == CW'(PAD_CYCLES - 1)) begin
                        state_d   = S_DATA;
                        din_d     = sr_q[NBITS-1];
                        sr_d      = sr_q << 1;
                        valid_n_d = 1'b0;
                        frame_n_d = (NBITS == 1);
                        cnt_d     = CW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(NBITS)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    active_d  = 1'b1;
                    frame_n_d = 1'b0;
                    if (!tx_pause) begin
                        din_d     = sr_q[NBITS-1];
                        sr_d      = sr_q << 1;
                        valid_n_d = 1'b0;
                        frame_n_d = (cnt_q == CW'(NBITS - 1));
                        cnt_d     = cnt_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(IFG - 1)) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            sr_q      <= '0;
            din_q     <= 1'b0;
            valid_n_q <= 1'b1;
            frame_n_q <= 1'b1;
            ready_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sr_q      <= sr_d;
            din_q     <= din_d;
            valid_n_q <= valid_n_d;
            frame_n_q <= frame_n_d;
            ready_q   <= ready_d;
            active_q  <= active_d;
        end
    end

    assign req_ready = ready_q;
    assign din       = din_q;
    assign valid_n   = valid_n_q;
    assign frame_n   = frame_n_q;
    assign tx_active = active_q;

endmodule

// File: tb/tb_router_packet_tx.sv
// Directed bench for router_packet_tx: decodes the serial wire and compares
// against hand-computed packets (parity variants when TX_PARITY_EN is set).
module tb_router_packet_tx;

`ifdef TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic [7:0] req_data;
    logic       dest_busy;
    logic       tx_pause;
    logic       din;
    logic       valid_n;
    logic       frame_n;
    logic       tx_active;

    int npass = 0;
    int ntot  = 0;

    router_packet_tx #(.DATA_W(8), .PAD_CYCLES(4), .IFG(1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .dest_busy (dest_busy),
        .tx_pause  (tx_pause),
        .din       (din),
        .valid_n   (valid_n),
        .frame_n   (frame_n),
        .tx_active (tx_active)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        ntot++;
        if (got === want) npass++;
        else $display("FAIL %s got=%0h want=%0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Payload as it appears on the wire: data, plus hand-given parity bit.
    function automatic logic [31:0] pk(input logic [7:0] d, input logic p);
        if (PB == 1) return {23'd0, d, p};
        return {24'd0, d};
    endfunction

    task automatic send(input logic [3:0] a, input logic [7:0] d,
                        input bit hold);
        int n = 0;
        while (req_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("ready_wait", req_ready, 1);
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    // Decodes one frame starting at the current (first address) cycle.
    task automatic capture(input string tag, input logic [3:0] ea,
                           input logic [31:0] ed, input int epad,
                           input int epau, input int etot);
        logic [3:0]  a = '0;
        logic [31:0] d = '0;
        int pad = 0, pau = 0, tot = 0, ferr = 0, nb = 0;
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (i < 4) begin
                a = {a[2:0], din};
                if (frame_n !== 1'b0 || valid_n !== 1'b1) ferr++;
            end else if (valid_n === 1'b1) begin
                if (nb == 0) pad++;
                else pau++;
                if (frame_n !== 1'b0 || din !== 1'b0) ferr++;
            end else begin
                d = {d[30:0], din};
                nb++;
                if (frame_n === 1'b1) begin
                    done = 1;
                    tot  = i + 1;
                end
            end
            if (!done) tick();
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_addr"}, a, ea);
        check({tag, "_data"}, d, ed);
        check({tag, "_nbits"}, nb, 8 + PB);
        check({tag, "_pad"}, pad, epad);
        check({tag, "_pause"}, pau, epau);
        check({tag, "_len"}, tot, etot);
        check({tag, "_ferr"}, ferr, 0);
    endtask

    int n;

    initial begin
        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        dest_busy = 1'b0;
        tx_pause  = 1'b0;
        #12;
        check("rst_frame_n", frame_n, 1);
        check("rst_valid_n", valid_n, 1);
        check("rst_din", din, 0);
        check("rst_ready", req_ready, 0);
        check("rst_active", tx_active, 0);
        tick();
        reset_n = 1'b0;
        check("rst_ready_hold", req_ready, 0);
        tick();
        check("ready_after_rst", req_ready, 1);

        // Basic packet, first address bit one cycle after accept
        send(4'hA, 8'hC5, 0);
        check("t0_din", din, 1);
        check("t0_frame_n", frame_n, 0);
        check("t0_active", tx_active, 1);
        check("t0_ready", req_ready, 0);
        capture("basic", 4'hA, pk(8'hC5, 1'b0), 4, 0, 16 + PB);
        tick();
        check("gap_frame_n", frame_n, 1);
        check("gap_valid_n", valid_n, 1);
        check("gap_active", tx_active, 0);
        check("gap_ready", req_ready, 0);
        tick();
        check("idle_ready", req_ready, 1);

        // Destination busy for 5 cycles from the 2nd pad cycle
        send(4'h3, 8'h5A, 0);
        fork
            capture("busy", 4'h3, pk(8'h5A, 1'b0), 9, 0, 21 + PB);
            begin
                repeat (5) tick();
                dest_busy = 1'b1;
                repeat (5) tick();
                dest_busy = 1'b0;
            end
        join

        // Pause twice before bit 3, once before bit 7
        send(4'h6, 8'h96, 0);
        fork
            capture("pause", 4'h6, pk(8'h96, 1'b0), 4, 3, 19 + PB);
            begin
                repeat (10) tick();
                tx_pause = 1'b1;
                repeat (2) tick();
                tx_pause = 1'b0;
                repeat (4) tick();
                tx_pause = 1'b1;
                tick();
                tx_pause = 1'b0;
            end
        join

        // Back-to-back held requests
        send(4'h9, 8'h81, 1);
        req_addr = 4'h4;
        req_data = 8'h7E;
        capture("b2b_a", 4'h9, pk(8'h81, 1'b0), 4, 0, 16 + PB);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (tx_active === 1'b1) break;
        end
        req_valid = 1'b0;
        check("b2b_period", 15 + PB + n, 18 + PB);
        capture("b2b_b", 4'h4, pk(8'h7E, 1'b0), 4, 0, 16 + PB);

        // Reset pulse during data bit 4
        send(4'h5, 8'hC3, 0);
        repeat (12) tick();
        check("pre_rst_valid_n", valid_n, 0);
        check("pre_rst_din", din, 0);
        reset_n = 1'b1;
        #1;
        check("mid_rst_frame_n", frame_n, 1);
        check("mid_rst_valid_n", valid_n, 1);
        check("mid_rst_active", tx_active, 0);
        tick();
        reset_n = 1'b0;
        tick();
        check("post_rst_ready", req_ready, 1);
        send(4'h2, 8'h3C, 0);
        capture("post_rst", 4'h2, pk(8'h3C, 1'b0), 4, 0, 16 + PB);

`ifdef TX_PARITY_EN
        send(4'h0, 8'h01, 0);
        capture("par1", 4'h0, 32'h003, 4, 0, 17);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
